// File: rtl/iis_tx_stream_pkg.sv
// Shared constants, FSM state encoding and parameter sanity checks for the I2S transmitter.
package iis_tx_stream_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_WAIT_L = 4'b0010,
    ST_LEFT   = 4'b0100,
    ST_RIGHT  = 4'b1000
  } iis_state_e;

  function automatic bit widths_ok(input int data_w, input int slot_w, input int mode);
    return (data_w >= 8) && (data_w <= 32) && (slot_w >= data_w) && (slot_w <= 32) &&
           ((mode == MODE_I2S) || (mode == MODE_LJ));
  endfunction

endpackage

// File: rtl/iis_tx_stream_if.sv
// Sample-pair valid/ready stream feeding the I2S transmitter.
interface iis_tx_stream_if #(
  parameter int DATA_W = 24
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_ldata;
  logic [DATA_W-1:0] s_rdata;

  modport master (output s_valid, output s_ldata, output s_rdata, input s_ready);
  modport slave  (input s_valid, input s_ldata, input s_rdata, output s_ready);
endinterface

// File: rtl/iis_tx_stream_edge_sync.sv
// Two-flop synchroniser for a codec clock pin plus single-cycle rise/fall strobes.
module iis_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_d};
      r_prev <= r_sync[1];
    end
  end

  assign o_rise = r_sync[1] & ~r_prev;
  assign o_fall = ~r_sync[1] & r_prev;
endmodule

// File: rtl/iis_tx_stream.sv
// I2S / left-justified slave transmitter: one-entry sample hold, slot FSM, serialiser and error flags.
module iis_tx_stream
  import iis_tx_stream_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32,
  parameter int MODE   = MODE_I2S
) (
  input  logic           clk_100m,
  input  logic           rst_n,
  input  logic           en,
  input  logic           bclk,
  input  logic           lrclk,
  iis_tx_stream_if.slave s,
  output logic           sdata_o,
  output logic           underrun,
  output logic           frame_err
);
  localparam int               CNT_W   = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W);

  if (!widths_ok(DATA_W, SLOT_W, MODE)) begin : g_bad_cfg
    $error("iis_tx_stream: unsupported DATA_W/SLOT_W/MODE combination");
  end

  iis_state_e        r_state, w_state_next;
  logic              w_bclk_fall, w_bclk_rise_unused, w_lr_rise, w_lr_fall;
  logic              w_l_start, w_r_start, w_accept, w_shift;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_l, r_hold_r, r_shl, r_shr, w_shl, w_shr;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic              r_skip, w_skip;
  logic              r_sdata, r_underrun, r_frame_err;

  iis_edge_sync u_bclk_sync (
    .i_clk (clk_100m), .i_rst_n(rst_n), .i_d(bclk),
    .o_rise(w_bclk_rise_unused), .o_fall(w_bclk_fall)
  );

  iis_edge_sync u_lr_sync (
    .i_clk (clk_100m), .i_rst_n(rst_n), .i_d(lrclk),
    .o_rise(w_lr_rise), .o_fall(w_lr_fall)
  );

  assign s.s_ready = en & ~r_hold_full & (r_state != ST_IDLE);
  assign w_accept  = s.s_valid & s.s_ready;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_l_start    = 1'b0;
    w_r_start    = 1'b0;
    case (r_state)
      ST_IDLE:   w_state_next = ST_WAIT_L;
      ST_WAIT_L: if (w_lr_fall) begin
        w_state_next = ST_LEFT;
        w_l_start    = 1'b1;
      end
      ST_LEFT, ST_RIGHT: begin
        if (w_lr_fall) begin
          w_state_next = ST_LEFT;
          w_l_start    = 1'b1;
        end else if (w_lr_rise) begin
          w_state_next = ST_RIGHT;
          w_r_start    = 1'b1;
        end
      end
      default:   w_state_next = ST_IDLE;
    endcase
    if (!en) begin
      w_state_next = ST_IDLE;
      w_l_start    = 1'b0;
      w_r_start    = 1'b0;
    end
  end

  // Slot-start values are resolved first so a coincident bclk_fall shifts the freshly loaded word.
  always_comb begin
    w_shl  = r_shl;
    w_shr  = r_shr;
    w_cnt  = r_cnt;
    w_skip = r_skip;
    if (w_l_start) begin
      if (r_hold_full) begin
        w_shl = r_hold_l;
        w_shr = r_hold_r;
      end else if (s.s_valid) begin
        w_shl = s.s_ldata;
        w_shr = s.s_rdata;
      end else begin
        w_shl = '0;
        w_shr = '0;
      end
      w_cnt  = '0;
      w_skip = (MODE == MODE_I2S);
    end else if (w_r_start) begin
      w_cnt  = '0;
      w_skip = (MODE == MODE_I2S);
    end
  end

  assign w_shift = w_bclk_fall & ((w_state_next == ST_LEFT) | (w_state_next == ST_RIGHT));

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_shl       <= '0;
      r_shr       <= '0;
      r_cnt       <= '0;
      r_skip      <= 1'b0;
      r_sdata     <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (!en) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_shl       <= '0;
      r_shr       <= '0;
      r_cnt       <= '0;
      r_skip      <= 1'b0;
      r_sdata     <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_underrun  <= w_l_start & ~r_hold_full & ~s.s_valid;
      r_frame_err <= (w_l_start | w_r_start) & (r_state != ST_WAIT_L) &
                     (r_cnt != '0) & (r_cnt < CNT_MAX);
      if (w_l_start && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_accept && !w_l_start) begin
        r_hold_full <= 1'b1;
        r_hold_l    <= s.s_ldata;
        r_hold_r    <= s.s_rdata;
      end
      r_shl  <= w_shl;
      r_shr  <= w_shr;
      r_cnt  <= w_cnt;
      r_skip <= w_skip;
      if (w_shift) begin
        if (w_cnt < CNT_MAX) r_cnt <= w_cnt + CNT_W'(1);
        if (w_skip) begin
          r_sdata <= 1'b0;
          r_skip  <= 1'b0;
        end else if (w_state_next == ST_LEFT) begin
          r_sdata <= w_shl[DATA_W-1];
          r_shl   <= {w_shl[DATA_W-2:0], 1'b0};
        end else begin
          r_sdata <= w_shr[DATA_W-1];
          r_shr   <= {w_shr[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign sdata_o   = r_sdata;
  assign underrun  = r_underrun;
  assign frame_err = r_frame_err;
endmodule
